// File: rtl/people_pool_controller.sv
// people_pool_controller
//   Passenger pool for the elevator simulation. Spawns people into a fixed
//   slot table at a speed-scaled rate. Boards and unloads them while the car
//   doors are open. Publishes request/destination bitmaps and occupancy
//   counters.
//
//   Optional feature macro: PEOPLE_REJECT_CNT_EN (adds the 'rejected' output).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sim_state[1:0]           00 STOP, 01 RUN, 10 PAUSE, 11 CLEAR (acts as reset)
//   sim_speed[2:0]           spawn period = BASE_PERIOD >> sim_speed (min 1)
//   randy[RAND_W-1:0]        random value, sampled on spawn ticks
//   door_open, car_floor     door pulse and the floor the car is at
//   people, riders           occupied slots / riding slots
//   people_generated         lifetime successful spawns (wraps)
//   floors_requested         bit f: some WAIT slot has origin f (registered)
//   floor_destinations       bit f: some RIDE slot has destination f (registered)
//   busy, scan_done          scan in progress / one-cycle scan-complete pulse
//   rejected                 (PEOPLE_REJECT_CNT_EN) saturating dropped-spawn count
//   scan_state_dbg[1:0]      scan FSM state: 0 IDLE, 1 SCAN, 2 DONE
//
// Handshake: door_open is a one-cycle request accepted only while the scan
//   FSM is IDLE. Acceptance shows as busy=1 on the following cycle. Requests
//   that arrive while busy is high, or in the DONE cycle, are dropped.
module people_pool_controller #(
  parameter int MAX_PEOPLE  = 63,
  parameter int PCNT_W      = 6,
  parameter int FLOORS      = 12,
  parameter int FLOOR_W     = 4,
  parameter int RAND_W      = 10,
  parameter int CAR_CAP     = 8,
  parameter int BASE_PERIOD = 1024,
  parameter int GEN_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sim_state,
  input  logic [2:0]        sim_speed,
  input  logic [RAND_W-1:0] randy,
  input  logic              door_open,
  input  logic [FLOOR_W-1:0] car_floor,
  output logic [PCNT_W-1:0] people,
  output logic [PCNT_W-1:0] riders,
  output logic [GEN_W-1:0]  people_generated,
  output logic [FLOORS-1:0] floors_requested,
  output logic [FLOORS-1:0] floor_destinations,
  output logic              busy,
  output logic              scan_done,
`ifdef PEOPLE_REJECT_CNT_EN
  output logic [GEN_W-1:0]  rejected,
`endif
  output logic [1:0]        scan_state_dbg
);

  localparam int IDX_W  = (MAX_PEOPLE > 1) ? $clog2(MAX_PEOPLE) : 1;
  localparam int TICK_W = $clog2(BASE_PERIOD + 1);
  localparam logic [FLOOR_W-1:0] FLOOR_MAX = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_N   = FLOOR_W'(FLOORS);
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_CLEAR = 2'b11;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT, SLOT_RIDE} slot_st_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} scan_st_e;

  // Raw random floor fields only exceed the floor range by less than FLOORS,
  // so one conditional subtraction is enough.
  function automatic logic [FLOOR_W-1:0] reduce_floor(input logic [FLOOR_W-1:0] f);
    if (f > FLOOR_MAX) return f - FLOOR_N;
    return f;
  endfunction

  slot_st_e           slot_st_q  [MAX_PEOPLE];
  slot_st_e           slot_st_d  [MAX_PEOPLE];
  logic [FLOOR_W-1:0] slot_org_q [MAX_PEOPLE];
  logic [FLOOR_W-1:0] slot_org_d [MAX_PEOPLE];
  logic [FLOOR_W-1:0] slot_dst_q [MAX_PEOPLE];
  logic [FLOOR_W-1:0] slot_dst_d [MAX_PEOPLE];

  scan_st_e           scan_q, scan_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [FLOOR_W-1:0] scan_floor_q, scan_floor_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [PCNT_W-1:0]  people_q, people_d;
  logic [PCNT_W-1:0]  riders_q, riders_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [FLOORS-1:0]  req_q, req_d;
  logic [FLOORS-1:0]  dst_q, dst_d;

  logic               clear;
  logic [TICK_W-1:0]  period;
  logic               spawn_tick;
  logic               rand_ok;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               spawn_ok;
  logic [FLOOR_W-1:0] new_org;
  logic [FLOOR_W-1:0] new_dst_raw;
  logic [FLOOR_W-1:0] new_dst;

  assign clear = rst | (sim_state == ST_CLEAR);
  assign busy  = (scan_q == S_SCAN);

  // Spawn tick generation and spawn-slot selection
  always_comb begin
    period = TICK_W'(BASE_PERIOD) >> sim_speed;
    if (period == '0) period = TICK_W'(1);
    // '>=' also recovers cleanly if sim_speed shortens the period mid-count
    spawn_tick = (sim_state == ST_RUN) && (tick_q >= period - TICK_W'(1));
    tick_d = tick_q;
    if (sim_state == ST_RUN) tick_d = spawn_tick ? '0 : tick_q + TICK_W'(1);

    rand_ok = (randy[RAND_W-1 -: 2] != 2'b00);

    // Descending loop so the lowest free index wins
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_PEOPLE - 1; i >= 0; i--) begin
      if (slot_st_q[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    new_org     = reduce_floor(randy[FLOOR_W-1:0]);
    new_dst_raw = reduce_floor(randy[2*FLOOR_W-1:FLOOR_W]);
    new_dst     = new_dst_raw;
    if (new_dst_raw == new_org) new_dst = (new_org == FLOOR_MAX) ? '0 : new_org + FLOOR_W'(1);

    spawn_ok = spawn_tick & rand_ok & free_found & ~busy;
  end

  // Scan FSM next state and slot table updates. Spawning only happens
  // while not scanning, so the two never touch the table in the same cycle.
  always_comb begin
    slot_st_d    = slot_st_q;
    slot_org_d   = slot_org_q;
    slot_dst_d   = slot_dst_q;
    scan_d       = scan_q;
    scan_idx_d   = scan_idx_q;
    scan_floor_d = scan_floor_q;
    people_d     = people_q;
    riders_d     = riders_q;
    gen_d        = gen_q;

    case (scan_q)
      S_IDLE: begin
        if (door_open) begin
          scan_d       = S_SCAN;
          scan_idx_d   = '0;
          scan_floor_d = car_floor;
        end
      end
      S_SCAN: begin
        // Unload before board, and use the live rider count, so a
        // lower-index unload makes room for a higher-index boarder.
        if (slot_st_q[scan_idx_q] == SLOT_RIDE && slot_dst_q[scan_idx_q] == scan_floor_q) begin
          slot_st_d[scan_idx_q] = SLOT_FREE;
          people_d = people_q - PCNT_W'(1);
          riders_d = riders_q - PCNT_W'(1);
        end else if (slot_st_q[scan_idx_q] == SLOT_WAIT && slot_org_q[scan_idx_q] == scan_floor_q
                     && riders_q < PCNT_W'(CAR_CAP)) begin
          slot_st_d[scan_idx_q] = SLOT_RIDE;
          riders_d = riders_q + PCNT_W'(1);
        end
        if (scan_idx_q == IDX_W'(MAX_PEOPLE - 1)) scan_d = S_DONE;
        else scan_idx_d = scan_idx_q + IDX_W'(1);
      end
      S_DONE:  scan_d = S_IDLE;
      default: scan_d = S_IDLE;
    endcase

    if (spawn_ok) begin
      slot_st_d[free_idx]  = SLOT_WAIT;
      slot_org_d[free_idx] = new_org;
      slot_dst_d[free_idx] = new_dst;
      people_d = people_q + PCNT_W'(1);
      gen_d    = gen_q + GEN_W'(1);
    end
  end

  // Bitmaps are built from the current table and registered, so they lag
  // slot changes by one cycle.
  always_comb begin
    req_d = '0;
    dst_d = '0;
    for (int i = 0; i < MAX_PEOPLE; i++) begin
      if (slot_st_q[i] == SLOT_WAIT) req_d[slot_org_q[i]] = 1'b1;
      if (slot_st_q[i] == SLOT_RIDE) dst_d[slot_dst_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < MAX_PEOPLE; i++) begin
        slot_st_q[i]  <= SLOT_FREE;
        slot_org_q[i] <= '0;
        slot_dst_q[i] <= '0;
      end
      scan_q       <= S_IDLE;
      scan_idx_q   <= '0;
      scan_floor_q <= '0;
      tick_q       <= '0;
      people_q     <= '0;
      riders_q     <= '0;
      gen_q        <= '0;
      req_q        <= '0;
      dst_q        <= '0;
    end else begin
      slot_st_q    <= slot_st_d;
      slot_org_q   <= slot_org_d;
      slot_dst_q   <= slot_dst_d;
      scan_q       <= scan_d;
      scan_idx_q   <= scan_idx_d;
      scan_floor_q <= scan_floor_d;
      tick_q       <= tick_d;
      people_q     <= people_d;
      riders_q     <= riders_d;
      gen_q        <= gen_d;
      req_q        <= req_d;
      dst_q        <= dst_d;
    end
  end

`ifdef PEOPLE_REJECT_CNT_EN
  logic [GEN_W-1:0] rej_q, rej_d;

  always_comb begin
    rej_d = rej_q;
    if (spawn_tick && rand_ok && (!free_found || busy) && rej_q != '1)
      rej_d = rej_q + GEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) rej_q <= '0;
    else       rej_q <= rej_d;
  end

  assign rejected = rej_q;
`endif

  assign people             = people_q;
  assign riders             = riders_q;
  assign people_generated   = gen_q;
  assign floors_requested   = req_q;
  assign floor_destinations = dst_q;
  assign scan_done          = (scan_q == S_DONE);
  assign scan_state_dbg     = scan_q;

endmodule

// File: tb/tb_people_pool_controller.sv
// tb_people_pool_controller
//   Directed bench for people_pool_controller with default parameters
//   (63 slots, 12 floors, CAR_CAP 8). Spawn period is 8 clocks at sim_speed 7.
module tb_people_pool_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sim_state;
  logic [2:0]  sim_speed;
  logic [9:0]  randy;
  logic        door_open;
  logic [3:0]  car_floor;
  logic [5:0]  people;
  logic [5:0]  riders;
  logic [15:0] people_generated;
  logic [11:0] floors_requested;
  logic [11:0] floor_destinations;
  logic        busy;
  logic        scan_done;
`ifdef PEOPLE_REJECT_CNT_EN
  logic [15:0] rejected;
`endif
  logic [1:0]  scan_state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [1:0] STOP  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  people_pool_controller dut (
    .clk                (clk),
    .rst                (rst),
    .sim_state          (sim_state),
    .sim_speed          (sim_speed),
    .randy              (randy),
    .door_open          (door_open),
    .car_floor          (car_floor),
    .people             (people),
    .riders             (riders),
    .people_generated   (people_generated),
    .floors_requested   (floors_requested),
    .floor_destinations (floor_destinations),
    .busy               (busy),
    .scan_done          (scan_done),
`ifdef PEOPLE_REJECT_CNT_EN
    .rejected           (rejected),
`endif
    .scan_state_dbg     (scan_state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Full door cycle: pulse plus 64 cycles, leaving the FSM back in IDLE.
  task automatic do_scan(input logic [3:0] f);
    door_open = 1'b1;
    car_floor = f;
    cyc(1);
    door_open = 1'b0;
    cyc(64);
  endtask

  task automatic run_cycles(input logic [9:0] r, input int n);
    randy     = r;
    sim_state = RUN;
    cyc(n);
    sim_state = STOP;
  endtask

  initial begin
    rst = 1'b1; sim_state = STOP; sim_speed = 3'd7; randy = '0;
    door_open = 1'b0; car_floor = '0;
    cyc(2);
    rst = 1'b0;
    chk("rst_people", people, 0);
    chk("rst_riders", riders, 0);
    chk("rst_gen", people_generated, 0);
    chk("rst_req", floors_requested, 0);
    chk("rst_dst", floor_destinations, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", scan_done, 0);

    // 3C5: origin 5, dest 12 -> 0. Tick holds through PAUSE.
    randy = 10'h3C5; sim_state = RUN; cyc(4);
    sim_state = PAUSE; cyc(10);
    sim_state = RUN; cyc(3);
    chk("pre_spawn_people", people, 0);
    cyc(1);
    sim_state = STOP;
    chk("spawn1_people", people, 1);
    chk("spawn1_gen", people_generated, 1);
    cyc(1);
    chk("spawn1_req", floors_requested, 12'h020);
    chk("spawn1_dst_wait", floor_destinations, 12'h000);

    // Door at floor 5: busy for 63 cycles, scan_done on cycle 64.
    // A second door_open mid-scan must be ignored.
    door_open = 1'b1; car_floor = 4'd5; cyc(1);
    door_open = 1'b0;
    chk("scan_busy_first", busy, 1);
    cyc(9);
    door_open = 1'b1; car_floor = 4'd0; cyc(1);
    door_open = 1'b0;
    cyc(52);
    chk("scan_busy_last", busy, 1);
    chk("scan_done_early", scan_done, 0);
    cyc(1);
    chk("scan_done_pulse", scan_done, 1);
    chk("scan_busy_drop", busy, 0);
    chk("board_riders", riders, 1);
    cyc(1);
    chk("scan_done_clear", scan_done, 0);
    chk("board_req", floors_requested, 12'h000);
    chk("board_dst", floor_destinations, 12'h001);
    do_scan(4'd0);
    chk("unload_people", people, 0);
    chk("unload_riders", riders, 0);

    // randy top bits 00: attempt dropped.
    run_cycles(10'h055, 8);
    chk("rand00_people", people, 0);
    chk("rand00_gen", people_generated, 1);

    // 255: origin 5, dest 5 -> 6.
    run_cycles(10'h255, 8);
    chk("dest_adj_people", people, 1);
    do_scan(4'd5);
    chk("dest_adj_dst", floor_destinations, 12'h040);
    do_scan(4'd6);
    chk("dest_adj_unload", people, 0);

    // 3BB: origin 11, dest 11 -> wraps to 0.
    run_cycles(10'h3BB, 8);
    cyc(1);
    chk("wrap_req", floors_requested, 12'h800);
    do_scan(4'd11);
    chk("wrap_dst", floor_destinations, 12'h001);
    do_scan(4'd0);
    chk("wrap_unload", people, 0);

    // 27E: origin 14 -> 2, dest 7.
    run_cycles(10'h27E, 8);
    cyc(1);
    chk("reduce_req", floors_requested, 12'h004);
    do_scan(4'd2);
    chk("reduce_dst", floor_destinations, 12'h080);
    do_scan(4'd7);
    chk("reduce_unload", people, 0);

    // Ten waiting at floor 3 (dest 9); car capacity is 8.
    run_cycles(10'h393, 80);
    chk("cap_people", people, 10);
    chk("cap_gen", people_generated, 14);
    do_scan(4'd3);
    chk("cap_riders", riders, 8);
    chk("cap_people_after", people, 10);
    chk("cap_req", floors_requested, 12'h008);
    chk("cap_dst", floor_destinations, 12'h200);
    do_scan(4'd9);
    chk("cap_unload_people", people, 2);
    chk("cap_unload_riders", riders, 0);

    // Fill all 63 slots, then one more attempt with nowhere to go.
    run_cycles(10'h393, 488);
    chk("full_people", people, 63);
    chk("full_gen", people_generated, 75);
    run_cycles(10'h3C5, 8);
    chk("full_people_hold", people, 63);
    chk("full_gen_hold", people_generated, 75);
`ifdef PEOPLE_REJECT_CNT_EN
    chk("full_rejected", rejected, 1);
`endif

    // Abort a scan with CLEAR.
    door_open = 1'b1; car_floor = 4'd3; cyc(1);
    door_open = 1'b0;
    cyc(5);
    chk("mid_busy", busy, 1);
    chk("mid_riders", riders, 5);
    sim_state = CLEAR; cyc(1);
    sim_state = STOP;
    chk("clr_busy", busy, 0);
    chk("clr_people", people, 0);
    chk("clr_riders", riders, 0);
    chk("clr_gen", people_generated, 0);
    chk("clr_req", floors_requested, 0);
    chk("clr_dst", floor_destinations, 0);
    chk("clr_done", scan_done, 0);
`ifdef PEOPLE_REJECT_CNT_EN
    chk("clr_rejected", rejected, 0);
`endif
    // Tick counter restarted at 0: spawn lands on the 8th RUN cycle.
    run_cycles(10'h3C5, 7);
    chk("clr_tick_pre", people, 0);
    run_cycles(10'h3C5, 1);
    chk("clr_tick_spawn", people, 1);
    chk("clr_tick_gen", people_generated, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
